// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared state encoding, field limits and wrap/clamp helpers for time setting
package time_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_H  = 2'd1,
    ST_SET_M  = 2'd2,
    ST_COMMIT = 2'd3
  } set_state_t;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

  // Out-of-range live values are treated as midnight rather than stored as-is.
  function automatic logic [4:0] hours_clamp(input logic [4:0] h);
    return (h > HOURS_MAX) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] minutes_clamp(input logic [5:0] m);
    return (m > MINUTES_MAX) ? 6'd0 : m;
  endfunction

  // The >= guard keeps a corrupted field from counting up through illegal values.
  function automatic logic [4:0] hours_inc(input logic [4:0] h);
    return (h >= HOURS_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] minutes_inc(input logic [5:0] m);
    return (m >= MINUTES_MAX) ? 6'd0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debounce filter and rising-edge press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;
  logic          level_q;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_2 != level) begin
      if (stable_cnt == CNT_LAST) begin
        level      <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  // Registered one-cycle pulse on each accepted 0->1 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - two-button hours/minutes editor with auto-repeat, blink and load strobe
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 50,
  parameter int BLINK_CYCLES    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic       load,
  output logic       hold,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  set_state_t    state;
  set_state_t    next_state;
  logic          mode_press;
  logic          mode_level_unused;
  logic          inc_press;
  logic          inc_level;
  logic          in_edit;
  logic          next_in_edit;
  logic          rep_active;
  logic [RW-1:0] rep_cnt;
  logic          rep_evt;
  logic          inc_evt;
  logic          apply_inc;
  logic [BW-1:0] blink_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .level   (mode_level_unused),
    .press   (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_inc),
    .level   (inc_level),
    .press   (inc_press)
  );

  assign in_edit      = (state == ST_SET_H) || (state == ST_SET_M);
  assign next_in_edit = (next_state == ST_SET_H) || (next_state == ST_SET_M);
  assign rep_evt      = rep_active && inc_level && (rep_cnt == REP_LAST);
  assign inc_evt      = in_edit && (inc_press || rep_evt);
  // A mode press in the same cycle moves on and swallows the increment.
  assign apply_inc    = inc_evt && !mode_press;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; load/hold/mode are pure functions of the current state.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    hold       = 1'b0;
    mode       = state;
    case (state)
      ST_RUN:    if (mode_press) next_state = ST_SET_H;
      ST_SET_H:  if (mode_press) next_state = ST_SET_M;
      ST_SET_M:  if (mode_press) next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
    load = (state == ST_COMMIT);
    hold = (state != ST_RUN);
  end

  // Edited fields: capture live time on entry, then step the active field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_hours   <= 5'd0;
      set_minutes <= 6'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mode_press) begin
            set_hours   <= hours_clamp(cur_hours);
            set_minutes <= minutes_clamp(cur_minutes);
          end
        end
        ST_SET_H: if (apply_inc) set_hours <= hours_inc(set_hours);
        ST_SET_M: if (apply_inc) set_minutes <= minutes_inc(set_minutes);
        default: ;
      endcase
    end
  end

  // Auto-repeat timer: armed by an inc press, dropped on release or any state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_active <= 1'b0;
      rep_cnt    <= '0;
    end else if (!in_edit || (next_state != state) || !inc_level) begin
      rep_active <= 1'b0;
      rep_cnt    <= '0;
    end else if (inc_press) begin
      rep_active <= 1'b1;
      rep_cnt    <= '0;
    end else if (rep_active) begin
      rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
    end
  end

  // Blink: off outside editing, restarts high on field entry or a step, else toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (!next_in_edit) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if ((next_state != state) || apply_inc) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
